// File: rtl/stream_bit_counter_pkg.sv
// bc_pkg: shared FSM state type and count-width helper for stream_bit_counter
package bc_pkg;

    typedef enum logic [1:0] {RUN, FLUSH, HOLD} sbc_state_t;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stream_bit_counter_popcount_tree.sv
// popcount_tree: combinational 1-bit counter built as a layered pairwise adder tree
//   i_bits  [WID_CountRange-1:0]  word to count
//   o_count [count_width-1:0]     number of 1s in i_bits
module popcount_tree
    import bc_pkg::*;
#(
    parameter int WID_CountRange = 64
) (
    input  logic [WID_CountRange-1:0]              i_bits,
    output logic [count_width(WID_CountRange)-1:0] o_count
);
    localparam int LVL = $clog2(WID_CountRange);
    localparam int PAD = 1 << LVL;
    localparam int WID_Count = count_width(WID_CountRange);

    logic [PAD-1:0] w_pad;
    assign w_pad = PAD'(i_bits);

    // Level i holds PAD>>i partial sums of i+1 bits; level 0 is the padded word itself.
    for (genvar i = 0; i <= LVL; i++) begin : g_lvl
        logic [i:0] s [PAD>>i];
        for (genvar j = 0; j < (PAD >> i); j++) begin : g_n
            if (i == 0) begin : g_leaf
                assign s[j] = w_pad[j];
            end else begin : g_add
                assign s[j] = {1'b0, g_lvl[i-1].s[2*j]} + {1'b0, g_lvl[i-1].s[2*j+1]};
            end
        end
    end

    // The root can be one bit wider than needed when the width is not a power of 2;
    // its top bit is then always 0 since the count never exceeds WID_CountRange.
    assign o_count = WID_Count'(g_lvl[LVL].s[0]);

endmodule

// File: rtl/stream_bit_counter.sv
// stream_bit_counter: streaming per-frame 1-bit counter with valid/ready in and out
//   clk, rst_n                 clock, asynchronous active-low reset
//   local_SBC_valid/_bitstream/_last  input word handshake, last marks end of frame
//   SBC_local_ready            block accepts a word (only in RUN)
//   SBC_local_valid/_result/_overflow frame total and sticky overflow, held until local_SBC_ready
//   SBC_SATURATE_EN            when defined the accumulator clamps at all-ones instead of wrapping
module stream_bit_counter
    import bc_pkg::*;
#(
    parameter int WID_CountRange  = 64,
    parameter int WID_CountResult = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       local_SBC_valid,
    input  logic [WID_CountRange-1:0]  local_SBC_bitstream,
    input  logic                       local_SBC_last,
    output logic                       SBC_local_ready,
    output logic                       SBC_local_valid,
    output logic [WID_CountResult-1:0] SBC_local_result,
    output logic                       SBC_local_overflow,
    input  logic                       local_SBC_ready
);
    localparam int WID_WordCount = count_width(WID_CountRange);

    sbc_state_t                 r_state;
    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic [WID_WordCount-1:0]   r_s1_count;
    logic [WID_CountResult-1:0] r_acc;
    logic                       r_ovf;
    logic [WID_WordCount-1:0]   w_count;
    logic                       w_accept;
    logic                       w_release;
    logic [WID_CountResult:0]   w_sum;
    logic [WID_CountResult-1:0] w_next_acc;

    popcount_tree #(.WID_CountRange(WID_CountRange)) u_tree (
        .i_bits (local_SBC_bitstream),
        .o_count(w_count)
    );

    assign SBC_local_ready = r_state == RUN;
    assign w_accept        = local_SBC_valid && SBC_local_ready;
    assign w_release       = r_state == HOLD && local_SBC_ready;
    assign w_sum           = {1'b0, r_acc} + (WID_CountResult + 1)'(r_s1_count);
`ifdef SBC_SATURATE_EN
    assign w_next_acc = w_sum[WID_CountResult] ? '1 : w_sum[WID_CountResult-1:0];
`else
    assign w_next_acc = w_sum[WID_CountResult-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= RUN;
            r_s1_valid         <= 1'b0;
            r_s1_last          <= 1'b0;
            r_s1_count         <= '0;
            r_acc              <= '0;
            r_ovf              <= 1'b0;
            SBC_local_valid    <= 1'b0;
            SBC_local_result   <= '0;
            SBC_local_overflow <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_count <= w_count;
                r_s1_last  <= local_SBC_last;
            end
            if (w_release) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_s1_valid) begin
                r_acc <= w_next_acc;
                r_ovf <= r_ovf | w_sum[WID_CountResult];
            end
            case (r_state)
                RUN: if (w_accept && local_SBC_last) r_state <= FLUSH;
                // Wait one edge for the last word to land in the accumulator, then publish.
                FLUSH: if (!(r_s1_valid && r_s1_last)) begin
                    SBC_local_result   <= r_acc;
                    SBC_local_overflow <= r_ovf;
                    SBC_local_valid    <= 1'b1;
                    r_state            <= HOLD;
                end
                HOLD: if (local_SBC_ready) begin
                    SBC_local_valid <= 1'b0;
                    r_state         <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_bit_counter.sv
// tb_stream_bit_counter: directed table plus corner sequences and a random frame scoreboard
module tb_stream_bit_counter;
    import bc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        lst = 1'b0;
    logic        dsr = 1'b1;
    logic [63:0] data = '0;
    int          sel = 0;

    logic        rdy64, val64, ovf64, rdy13, val13, ovf13, rdy8, val8, ovf8;
    logic [15:0] res64, res13;
    logic [3:0]  res8;
    logic        cur_ready, cur_valid, cur_ovf;
    logic [15:0] cur_res;

    int n_vec = 0;
    int n_mis = 0;
    int rx = 0;
    logic rand_on = 1'b0;
    logic rand_done = 1'b0;
    int exp_q[$];

    always #5 clk = ~clk;

    stream_bit_counter #(.WID_CountRange(64), .WID_CountResult(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .local_SBC_valid(vld && sel == 0), .local_SBC_bitstream(data),
        .local_SBC_last(lst), .SBC_local_ready(rdy64), .SBC_local_valid(val64),
        .SBC_local_result(res64), .SBC_local_overflow(ovf64), .local_SBC_ready(dsr));

    stream_bit_counter #(.WID_CountRange(13), .WID_CountResult(16)) dut13 (
        .clk(clk), .rst_n(rst_n), .local_SBC_valid(vld && sel == 1), .local_SBC_bitstream(data[12:0]),
        .local_SBC_last(lst), .SBC_local_ready(rdy13), .SBC_local_valid(val13),
        .SBC_local_result(res13), .SBC_local_overflow(ovf13), .local_SBC_ready(dsr));

    stream_bit_counter #(.WID_CountRange(8), .WID_CountResult(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .local_SBC_valid(vld && sel == 2), .local_SBC_bitstream(data[7:0]),
        .local_SBC_last(lst), .SBC_local_ready(rdy8), .SBC_local_valid(val8),
        .SBC_local_result(res8), .SBC_local_overflow(ovf8), .local_SBC_ready(dsr));

    always_comb begin
        cur_ready = sel == 0 ? rdy64 : sel == 1 ? rdy13 : rdy8;
        cur_valid = sel == 0 ? val64 : sel == 1 ? val13 : val8;
        cur_ovf   = sel == 0 ? ovf64 : sel == 1 ? ovf13 : ovf8;
        cur_res   = sel == 0 ? res64 : sel == 1 ? res13 : {12'b0, res8};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        data = d;
        lst  = l;
        vld  = 1'b1;
        for (int t = 0; !cur_ready; t++) begin
            if (t >= 200) begin
                chk("ready_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        vld = 1'b0;
        lst = 1'b0;
    endtask

    // Sends a frame with downstream ready high and checks latency, result and ready recovery.
    task automatic frame(input string nm, input int n, input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, input logic [15:0] er, input logic eo);
        logic [63:0] ws [3];
        ws = '{w0, w1, w2};
        dsr = 1'b1;
        for (int i = 0; i < n; i++) push(ws[i], i == n - 1);
        chk({nm, "_ready_flush"}, cur_ready, 0);
        chk({nm, "_valid_n0"}, cur_valid, 0);
        @(posedge clk); #1;
        chk({nm, "_valid_n1"}, cur_valid, 0);
        @(posedge clk); #1;
        chk({nm, "_valid_n2"}, cur_valid, 1);
        chk({nm, "_result"}, cur_res, er);
        chk({nm, "_overflow"}, cur_ovf, eo);
        @(posedge clk); #1;
        chk({nm, "_valid_after"}, cur_valid, 0);
        chk({nm, "_ready_after"}, cur_ready, 1);
    endtask

    typedef struct {
        int          s;
        int          n;
        logic [63:0] w0, w1, w2;
        logic [15:0] er;
        logic        eo;
    } vec_t;

    always @(negedge clk) begin
        if (rand_on && cur_valid && dsr) begin
            if (exp_q.size() == 0) chk("rand_extra_result", 1, 0);
            else chk("rand_frame", cur_res, exp_q.pop_front());
            rx++;
        end
    end

    initial begin
        vec_t tv [8];
        int   bad;
        tv[0] = '{0, 3, 64'h0F, 64'hFF, '1, 16'd76, 1'b0};
        tv[1] = '{0, 1, 64'h0, 64'h0, 64'h0, 16'd0, 1'b0};
        tv[2] = '{0, 1, '1, 64'h0, 64'h0, 16'd64, 1'b0};
        tv[3] = '{0, 2, 64'h8000_0000_0000_0001, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 16'd34, 1'b0};
        tv[4] = '{1, 1, 64'h1FFF, 64'h0, 64'h0, 16'd13, 1'b0};
        tv[5] = '{1, 2, 64'h1555, 64'h0AAA, 64'h0, 16'd13, 1'b0};
`ifdef SBC_SATURATE_EN
        tv[6] = '{2, 3, 64'hFF, 64'hFF, 64'hFF, 16'd15, 1'b1};
`else
        tv[6] = '{2, 3, 64'hFF, 64'hFF, 64'hFF, 16'd8, 1'b1};
`endif
        tv[7] = '{2, 1, 64'h01, 64'h0, 64'h0, 16'd1, 1'b0};

        #12;
        chk("reset_ready", rdy64, 1);
        chk("reset_valid", val64, 0);
        chk("reset_result", res64, 0);
        chk("reset_overflow", ovf64, 0);
        chk("count_width_13", 64'(count_width(13)), 4);
        chk("count_width_64", 64'(count_width(64)), 7);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            sel = tv[v].s;
            frame($sformatf("vec%0d", v), tv[v].n, tv[v].w0, tv[v].w1, tv[v].w2, tv[v].er, tv[v].eo);
        end

        sel = 0;
        dsr = 1'b0;
        push(64'h3, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        data = '1;
        lst  = 1'b1;
        vld  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold_stable", {cur_valid, cur_ready, cur_ovf, cur_res}, {1'b1, 1'b0, 1'b0, 16'd2});
        end
        dsr = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        lst = 1'b0;
        chk("hold_release_valid", cur_valid, 0);
        chk("hold_release_ready", cur_ready, 1);
        frame("after_hold", 1, 64'h1, 64'h0, 64'h0, 16'd1, 1'b0);

        for (int i = 0; i < 3; i++) push(64'hFF, 1'b0);
        rst_n = 1'b0;
        #3;
        chk("midreset_state", {cur_valid, cur_ready, cur_ovf, cur_res}, {1'b0, 1'b1, 1'b0, 16'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cur_valid) bad++;
        end
        chk("midreset_no_result", bad, 0);
        frame("after_reset", 1, 64'h3, 64'h0, 64'h0, 16'd2, 1'b0);

        rand_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 1000; f++) begin
                    int n;
                    int sum;
                    n   = $urandom_range(1, 20);
                    sum = 0;
                    for (int i = 0; i < n; i++) begin
                        logic [63:0] d;
                        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                        d = {$urandom, $urandom};
                        sum += $countones(d);
                        if (i == n - 1) exp_q.push_back(sum);
                        push(d, i == n - 1);
                    end
                end
                for (int t = 0; rx < 1000 && t < 5000; t++) begin @(posedge clk); #1; end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    dsr = $urandom_range(0, 3) != 0;
                end
                dsr = 1'b1;
            end
        join
        rand_on = 1'b0;
        chk("rand_frame_count", rx, 1000);
        chk("rand_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/stream_bit_counter.md
Name: stream_bit_counter

Overview:
- Clocked, streaming successor to the combinational bit counter.
- Accepts a frame of parametrised-width words over a valid/ready handshake and counts the 1-bits in each word through a registered adder tree.
- Accumulates the per-word counts across the frame, which ends at the word flagged `last`, and presents one frame total plus an overflow flag on an output handshake.
- Sits between a bitstream producer, such as a syndrome or error-pattern source, and downstream decision logic.

Parameters:
- WID_CountRange, default 64: input word width; must be > 1. Need not be a power of 2; unused tree inputs are tied to 0.
- WID_CountResult, default 16: frame accumulator and result width; must be >= WID_WordCount.
- WID_WordCount (derived localparam, not overridable): $clog2(WID_CountRange + 1), the per-word count width. It must hold WID_CountRange itself, so an all-ones word counts correctly.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- local_SBC_valid  in  1  input word valid.
- local_SBC_bitstream  in  WID_CountRange  input word.
- local_SBC_last  in  1  word is the final word of the frame.
- SBC_local_ready  out  1  block can accept a word.
- SBC_local_valid  out  1  frame result valid.
- SBC_local_result  out  WID_CountResult  frame 1-bit total.
- SBC_local_overflow  out  1  accumulator exceeded 2^WID_CountResult - 1 during the frame.
- local_SBC_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=RUN, stage-1 register cleared, accumulator=0, overflow=0.
  - SBC_local_valid=0, SBC_local_result=0, SBC_local_overflow=0, SBC_local_ready=1.
- Input accept: a word is accepted on any edge where local_SBC_valid & SBC_local_ready. Data and `last` are ignored otherwise; no combinational path from valid to ready.
- Stage 1 (one cycle): the registered per-word count = number of 1s in the accepted word, held in WID_WordCount bits, together with a registered copy of `last` and a stage-1 valid bit.
- Stage 2: when stage-1 valid, the accumulator adds the zero-extended count. The add is done in WID_CountResult+1 bits; a carry-out sets the sticky overflow.
- States:
  - RUN: SBC_local_ready=1. Accepting a word with last=1 -> FLUSH.
  - FLUSH: SBC_local_ready=0. The stage-1 last word is added into the accumulator, result and overflow are registered to the outputs -> HOLD.
  - HOLD: SBC_local_valid=1 and outputs stable. On local_SBC_ready=1: accumulator and overflow cleared, SBC_local_valid=0 next cycle -> RUN.
- Latency: last word accepted at edge N -> SBC_local_valid high after edge N+2. Back-to-back words in RUN give throughput of 1 word/cycle.
- Single-word frame (last on the first word) is legal; result = popcount of that word.
- Empty frames cannot be expressed, since `last` always rides on a word.
- Downstream backpressure: HOLD persists indefinitely with the result stable. Input stays stalled with SBC_local_ready=0 from the edge after the last word through the result-accept edge. SBC_local_ready returns to 1 in the cycle after the result is accepted.
- Accumulator overflow without the optional feature: wraps modulo 2^WID_CountResult; overflow is sticky until the result is accepted.
- Reset mid-frame: the partial frame is discarded; no result is emitted.

Optional Feature:
- Macro: SBC_SATURATE_EN.
- Defined: the accumulator clamps at all-ones, and further adds keep it at all-ones. Overflow is still set on the first clamp.
- Undefined: wrap-around as described in Behaviour.
- The port list is identical in both builds.

Decomposition:
- Package bc_pkg:
  - typedef enum logic [1:0] {RUN, FLUSH, HOLD} sbc_state_t;
  - function count_width(n) returning $clog2(n+1), used for WID_WordCount.
- Sub-module popcount_tree: purely combinational, parametrised by WID_CountRange. Pads its input to the next power of 2 with zeros and does a pairwise layered add, growing each layer's field by 1 bit. Its output is count_width(WID_CountRange) wide, and its unused upper bits are tied to 0.
- stream_bit_counter instantiates popcount_tree before the stage-1 register.

Test Plan:
- W=64, R=16, frame 0x0F, 0xFF, last 0xFFFF_FFFF_FFFF_FFFF with downstream ready high -> result=76, overflow=0, valid exactly 2 cycles after the last accept, ready back 1 cycle after result accept.
- W=13 (non-power-of-2), single word 0x1FFF with last -> result=13; also checks that 0x1FFF on its own yields WID_WordCount=4.
- Hold local_SBC_ready=0 for 10 cycles in HOLD -> result and overflow stable, SBC_local_ready=0 throughout, and words offered upstream are not consumed.
- W=8, R=4, three all-ones words -> without SBC_SATURATE_EN result=24 mod 16=8, overflow=1; with it result=15, overflow=1. Next frame 0x01 -> result=1, overflow=0.
- Random valid gaps, 1000 frames of random length 1..20 -> every result matches the reference model's per-frame popcount sum, with no lost or duplicated words.
- Assert rst_n low mid-frame after 3 words, then a new frame 0x03 with last -> result=2, and no spurious result from the aborted frame.
